// File: rtl/ir_nec_pkg.sv
// Shared types and constants for the NEC infrared transmitter.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } nec_state_e;

  // Durations in NEC units (562.5 us each).
  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned REP_SPACE_U  = 4;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned BIT_U        = 1;

  // Defaults for a 50 MHz clock.
  localparam int unsigned UNIT_CYC_DEF     = 28125;
  localparam int unsigned CARRIER_HALF_DEF = 658;

  // True for states during which the IR envelope is asserted.
  function automatic logic is_mark(input nec_state_e s);
    return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier: half-period counter plus toggle, restartable so every mark
// begins with a full high half-period. Output is the registered, gated carrier.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned CARRIER_HALF = CARRIER_HALF_DEF
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_gate,
  output logic o_led
);

  localparam int unsigned CntW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_phase;
  logic            w_phase_d;
  logic            r_led;

  // Next phase/count; restart forces the high half to begin on this edge.
  always_comb begin
    w_cnt_d   = r_cnt + CntW'(1);
    w_phase_d = r_phase;
    if (i_restart) begin
      w_cnt_d   = '0;
      w_phase_d = 1'b1;
    end else if (r_cnt == CntW'(CARRIER_HALF - 1)) begin
      w_cnt_d   = '0;
      w_phase_d = ~r_phase;
    end
  end

  // Carrier state and gated LED register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_phase <= w_phase_d;
      r_led   <= i_gate & w_phase_d;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/ir_nec.sv
// NEC IR transmitter: leader, 32 pulse-distance bits LSB first, stop mark and
// inter-frame gap, or the short repeat code. All outputs are registered.
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYC     = UNIT_CYC_DEF,
  parameter int unsigned CARRIER_HALF = CARRIER_HALF_DEF,
  parameter int unsigned MODULATE     = 1,
  parameter int unsigned GAP_UNITS    = 72
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_repeat_req,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ir_mark,
  output logic        o_ir_led,
  output logic        o_ir_rxd_loop
);

  localparam int unsigned CycW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

  nec_state_e      r_state, w_state_d;
  logic [CycW-1:0] r_cyc, w_cyc_d;
  logic [6:0]      r_units, w_units_d;
  logic [4:0]      r_bit, w_bit_d;
  logic [31:0]     r_shift, w_shift_d;
  logic            r_rep, w_rep_d;
  logic            r_busy, r_done, r_mark, r_rxd;

  logic [6:0]      w_dur;
  logic            w_unit_end;
  logic            w_state_end;
  logic            w_mark_d;
  logic            w_done_d;
  logic            w_carrier_led;

  // Length of the current state in units.
  always_comb begin
    w_dur = 7'd1;
    case (r_state)
      StLeadMark:  w_dur = 7'(LEAD_MARK_U);
      StLeadSpace: w_dur = r_rep ? 7'(REP_SPACE_U) : 7'(LEAD_SPACE_U);
      StBitMark:   w_dur = 7'(BIT_U);
      StBitSpace:  w_dur = r_shift[0] ? 7'(ONE_SPACE_U) : 7'(BIT_U);
      StStopMark:  w_dur = 7'(BIT_U);
      StGap:       w_dur = 7'(GAP_UNITS);
      default:     w_dur = 7'd1;
    endcase
  end

  assign w_unit_end  = (r_cyc == CycW'(UNIT_CYC - 1));
  assign w_state_end = w_unit_end && (r_units == (w_dur - 7'd1));

  // Next-state, counters and shift register.
  always_comb begin
    w_state_d = r_state;
    w_cyc_d   = r_cyc + CycW'(1);
    w_units_d = r_units;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_rep_d   = r_rep;
    if (r_state == StIdle) begin
      w_cyc_d   = '0;
      w_units_d = '0;
      w_bit_d   = '0;
      if (i_start) begin
        w_state_d = StLeadMark;
        w_shift_d = i_data;
        w_rep_d   = 1'b0;
      end else if (i_repeat_req) begin
        w_state_d = StLeadMark;
        w_rep_d   = 1'b1;
      end
    end else begin
      if (w_unit_end) begin
        w_cyc_d   = '0;
        w_units_d = r_units + 7'd1;
      end
      if (w_state_end) begin
        w_units_d = '0;
        case (r_state)
          StLeadMark:  w_state_d = StLeadSpace;
          StLeadSpace: w_state_d = r_rep ? StStopMark : StBitMark;
          StBitMark:   w_state_d = StBitSpace;
          StBitSpace: begin
            w_shift_d = {1'b0, r_shift[31:1]};
            w_bit_d   = r_bit + 5'd1;
            w_state_d = (r_bit == 5'd31) ? StStopMark : StBitMark;
          end
          StStopMark:  w_state_d = StGap;
          StGap:       w_state_d = StIdle;
          default:     w_state_d = StIdle;
        endcase
      end
    end
  end

  assign w_mark_d = is_mark(w_state_d);
  // done lands on the final gap cycle, so it is decoded from next-cycle values.
  assign w_done_d = (w_state_d == StGap) && (w_units_d == 7'(GAP_UNITS - 1)) &&
                    (w_cyc_d == CycW'(UNIT_CYC - 1));

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cyc   <= '0;
      r_units <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mark  <= 1'b0;
      r_rxd   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cyc   <= w_cyc_d;
      r_units <= w_units_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_rep   <= w_rep_d;
      r_busy  <= (w_state_d != StIdle);
      r_done  <= w_done_d;
      r_mark  <= w_mark_d;
      r_rxd   <= ~w_mark_d;
    end
  end

  // Marks never follow marks directly, so a rising envelope marks every mark entry.
  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .i_clk    (i_clk),
    .rst_n    (rst_n),
    .i_restart(w_mark_d & ~r_mark),
    .i_gate   (w_mark_d),
    .o_led    (w_carrier_led)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_ir_mark     = r_mark;
  assign o_ir_led      = (MODULATE != 0) ? w_carrier_led : r_mark;
  assign o_ir_rxd_loop = r_rxd;

endmodule

// File: doc/ir_nec_tx.md
# ir_nec_tx

NEC-protocol infrared transmitter: the send side of the link whose receive side feeds the keypad/SRAM front end. It serialises a 32-bit frame into leader, 32 pulse-distance bits (LSB first), stop mark and inter-frame gap, with optional 38 kHz carrier. It also emits the NEC repeat code. It drives an IR LED, and provides an active-low loopback line that plugs directly into IR_RECEIVE for board self-test.

## Interface
- UNIT_CYC, 28125: clocks per 562.5 µs NEC unit at 50 MHz.
- CARRIER_HALF, 658: clocks per carrier half-period (≈38 kHz).
- MODULATE, 1: 1 gates ir_led with the carrier; 0 makes ir_led equal to ir_mark.
- GAP_UNITS, 72: idle units enforced after every stop mark.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a data frame; sampled only in IDLE.
- repeat_req  in  1  request a repeat code; sampled only in IDLE.
- data  in  32  frame. [7:0] address, [15:8] address complement/extension, [23:16] keycode, [31:24] ~keycode. Bit 0 is sent first.
- busy  out  1  high from the cycle after acceptance until the gap ends.
- done  out  1  one-cycle pulse as the state machine returns to IDLE.
- ir_mark  out  1  envelope; 1 during a mark.
- ir_led  out  1  LED drive (carrier-gated envelope).
- ir_rxd_loop  out  1  ~ir_mark; idle high, matching the IRDA_RXD polarity.

## Operation
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- Unit durations:
  - LEAD_MARK: 16 units.
  - LEAD_SPACE: 8 units for a frame, 4 for a repeat.
  - BIT_MARK: 1 unit.
  - BIT_SPACE: 1 unit for a 0, 3 units for a 1.
  - STOP_MARK: 1 unit.
  - GAP: GAP_UNITS.
- Data frame path: LEAD_MARK → LEAD_SPACE → 32 × (BIT_MARK → BIT_SPACE) → STOP_MARK → GAP → IDLE.
- Repeat path: LEAD_MARK → LEAD_SPACE(4) → STOP_MARK → GAP → IDLE.
- data is copied into a shift register on acceptance and shifted right after each BIT_SPACE. Later changes to data do not affect the frame in flight.
- A 5-bit bit index counts 0..31. BIT_SPACE on index 31 goes to STOP_MARK.
- start and repeat_req are both ignored while busy; there is no queueing.
- If start and repeat_req are high together, start wins.
- A repeat is accepted even when no frame has been sent since reset.
- Carrier:
  - The phase counter restarts at every mark entry, so ir_led is high for the first CARRIER_HALF clocks of each mark.
  - Duty cycle is 50%.
  - ir_led is 0 throughout spaces and gap.
- Reset values: state IDLE; busy 0, done 0, ir_mark 0, ir_led 0, ir_rxd_loop 1; all counters and the shift register 0.
- An rst_n assertion mid-frame aborts the frame immediately and asynchronously, with no done pulse.

## Timing
- Acceptance: start (or repeat_req) high in IDLE at edge N. At edge N+1, busy=1, ir_mark=1, and the first unit begins.
- Every state lasts exactly (units × UNIT_CYC) clocks. Counters have no off-by-one slack.
- Unit counter: width $clog2(UNIT_CYC). It wraps at UNIT_CYC−1 and then advances the unit count (7 bits, covers up to GAP_UNITS ≤ 127).
- Frame length from ir_mark rise to end of the stop mark: (24 + 2·zeros + 4·ones + 1) units. The range is 89 units (all zeros) to 153 units (all ones).
- Repeat length: 21 units, plus the gap.
- done pulses in the last GAP cycle. busy falls on the next edge, and IDLE can accept a new request in that same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package ir_nec_pkg:
  - state enum;
  - unit-count constants (LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, ONE_SPACE_U=3, BIT_U=1);
  - default UNIT_CYC and CARRIER_HALF.
- One natural sub-module, ir_carrier_gen: the half-period counter plus toggle, with a restart input. The remaining FSM and datapath stay in ir_nec_tx.

## Test plan
- Reset, then idle 100 cycles → ir_mark=0, ir_led=0, ir_rxd_loop=1, busy=0. Assert rst_n low mid-LEAD_MARK → outputs return to these values immediately.
- UNIT_CYC=4, MODULATE=0, data=32'hEE11_FF00, pulse start → ir_mark high for 64 cycles then low for 32. Total 484 cycles (121 units) from first mark to stop-mark end. busy/done timing as specified.
- Same data, default parameters, ir_rxd_loop wired to IR_RECEIVE → IR_READY asserts once, with IR_DATA=32'hEE11_FF00 and keycode 8'h11.
- UNIT_CYC=4, pulse repeat_req → 64 mark, 16 space, 4 mark, then 4·GAP_UNITS idle; done after 84 + 288 cycles.
- start held high across an entire frame, with data changed mid-frame → exactly one frame per IDLE entry, each with the latched value. start and repeat_req asserted together → a data frame is sent.
- MODULATE=1, CARRIER_HALF=3, UNIT_CYC=24 → each bit mark shows 4 full carrier periods starting high. ir_led=0 in every space.
